// File: rtl/serial_compare_byte.sv
// -----------------------------------------------------------------------------
// serial_compare_byte
//
// Bit-serial unsigned magnitude comparator. Operands A and B arrive MSB-first
// on single-bit lines, one bit pair per clock, in a frame that begins with a
// one-cycle `start` pulse. The `start` cycle also carries bit WIDTH-1. After
// bit 0 has been sampled, the block pulses `done` for one cycle. On that same
// edge it registers the comparison result (`ga`, `eq`) and the deserialized
// operands (`byte_a`, `byte_b`). These results are held until the next `done`.
//
// Ports
//   clk     in   rising-edge system clock
//   rst_n   in   asynchronous active-low reset
//   start   in   frame start, accepted only while busy == 0
//   bit_a   in   serial operand A, MSB first
//   bit_b   in   serial operand B, MSB first
//   busy    out  frame in progress, more bits expected
//   done    out  one-cycle pulse, results valid
//   ga      out  A > B (unsigned), held until next done
//   eq      out  A == B, held until next done
//   byte_a  out  deserialized A, updated with done
//   byte_b  out  deserialized B, updated with done
//
// Every output comes from a register, so no combinational path runs from an
// input to an output.
// -----------------------------------------------------------------------------
module serial_compare_byte #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_a,
    input  logic             bit_b,
    output logic             busy,
    output logic             done,
    output logic             ga,
    output logic             eq,
    output logic [WIDTH-1:0] byte_a,
    output logic [WIDTH-1:0] byte_b
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;     // index of the bit pair sampled last
    logic [WIDTH-1:0] sh_a_q,  sh_a_d;
    logic [WIDTH-1:0] sh_b_q,  sh_b_d;
    logic             decided_q, decided_d;
    logic             gt_q,      gt_d;
    logic             done_d, ga_d, eq_d;
    logic [WIDTH-1:0] byte_a_d, byte_b_d;

    // The busy output comes straight from the state register. It is high
    // for cycles T+1..T+WIDTH-1 of a frame.
    assign busy = (state_q == SHIFT);

    // NOTE: every signal gets a default at the top of this block, so no path
    // leaves a variable unassigned and no latch is inferred. Blocking '=' is
    // correct here: later lines intentionally read the values assigned above.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        done_d    = 1'b0;
        ga_d      = ga;
        eq_d      = eq;
        byte_a_d  = byte_a;
        byte_b_d  = byte_b;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // The start cycle carries the MSB. The decision flags are
                    // rebuilt from this bit alone, which discards the previous
                    // frame's decision.
                    sh_a_d    = {{(WIDTH-1){1'b0}}, bit_a};
                    sh_b_d    = {{(WIDTH-1){1'b0}}, bit_b};
                    decided_d = bit_a ^ bit_b;
                    gt_d      = bit_a;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                // A start pulse that arrives during a frame is ignored.
                sh_a_d = {sh_a_q[WIDTH-2:0], bit_a};
                sh_b_d = {sh_b_q[WIDTH-2:0], bit_b};
                // The first differing bit position fixes the result. Less
                // significant bits cannot change it.
                if (!decided_q && (bit_a != bit_b)) begin
                    decided_d = 1'b1;
                    gt_d      = bit_a;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Bit 0 is being sampled, so the result is final.
                    done_d   = 1'b1;
                    ga_d     = decided_d & gt_d;
                    eq_d     = ~decided_d;
                    byte_a_d = sh_a_d;
                    byte_b_d = sh_b_d;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            done      <= 1'b0;
            ga        <= 1'b0;
            eq        <= 1'b0;
            byte_a    <= '0;
            byte_b    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            done      <= done_d;
            ga        <= ga_d;
            eq        <= eq_d;
            byte_a    <= byte_a_d;
            byte_b    <= byte_b_d;
        end
    end

endmodule

// File: tb/tb_serial_compare_byte.sv
// -----------------------------------------------------------------------------
// tb_serial_compare_byte
//
// Directed bench for serial_compare_byte with WIDTH = 8. Inputs change 1 ns
// after each rising edge. Outputs are sampled at the same point, away from
// the active edge. The expected results of the directed frames are written
// out by hand. The random frames use a reference comparison of the parallel
// operands, which plays the role of the parallel comparator.
// -----------------------------------------------------------------------------
module tb_serial_compare_byte;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         bit_a;
    logic         bit_b;
    logic         busy;
    logic         done;
    logic         ga;
    logic         eq;
    logic [W-1:0] byte_a;
    logic [W-1:0] byte_b;

    int total = 0;
    int bad   = 0;

    serial_compare_byte #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bit_a  (bit_a),
        .bit_b  (bit_b),
        .busy   (busy),
        .done   (done),
        .ga     (ga),
        .eq     (eq),
        .byte_a (byte_a),
        .byte_b (byte_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one frame, starting in the current cycle T.
    // ign_at > 0 adds a stray start pulse in cycle T+ign_at.
    // The task returns in cycle T+8, with the done pulse visible.
    task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int ign_at, input logic exp_ga,
                         input logic exp_eq, input string tag);
        start = 1'b1;
        bit_a = a[W-1];
        bit_b = b[W-1];
        tick();
        for (int k = 1; k < W; k++) begin
            check({tag, "_busy_mid"}, 32'(busy), 32'd1);
            check({tag, "_done_mid"}, 32'(done), 32'd0);
            start = (k == ign_at);
            bit_a = a[W-1-k];
            bit_b = b[W-1-k];
            tick();
        end
        start = 1'b0;
        check({tag, "_done"},   32'(done),   32'd1);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_ga"},     32'(ga),     32'(exp_ga));
        check({tag, "_eq"},     32'(eq),     32'(exp_eq));
        check({tag, "_byte_a"}, 32'(byte_a), 32'(a));
        check({tag, "_byte_b"}, 32'(byte_b), 32'(b));
    endtask

    // One idle cycle after a frame. done must have dropped, and the results
    // must be held.
    task automatic idle_after(input logic exp_ga, input logic exp_eq, input string tag);
        start = 1'b0;
        tick();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_ga_hold"},   32'(ga),   32'(exp_ga));
        check({tag, "_eq_hold"},   32'(eq),   32'(exp_eq));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] pa;

        rst_n = 1'b0;
        start = 1'b0;
        bit_a = 1'b0;
        bit_b = 1'b0;
        tick();
        tick();
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_ga",     32'(ga),     32'd0);
        check("rst_eq",     32'(eq),     32'd0);
        check("rst_byte_a", 32'(byte_a), 32'd0);
        check("rst_byte_b", 32'(byte_b), 32'd0);
        rst_n = 1'b1;
        // The bit lines are don't-care in IDLE when start is low.
        bit_a = 1'b1;
        tick();
        check("idle_no_start_busy", 32'(busy), 32'd0);

        // A > B. 0x5A = 0101_1010 and 0x3C = 0011_1100 first differ at bit 6.
        frame(8'h5A, 8'h3C, 0, 1'b1, 1'b0, "gt");
        idle_after(1'b1, 1'b0, "gt");

        // Equal operands.
        frame(8'h7F, 8'h7F, 0, 1'b0, 1'b1, "eq");
        idle_after(1'b0, 1'b1, "eq");

        // The MSB decides B > A. A's later 1 bit must not change the result.
        frame(8'h01, 8'h80, 0, 1'b0, 1'b0, "msb");
        idle_after(1'b0, 1'b0, "msb");

        // Back-to-back frames. The second start falls in the first done cycle.
        frame(8'h80, 8'h7F, 0, 1'b1, 1'b0, "b2b1");
        frame(8'h00, 8'h00, 0, 1'b0, 1'b1, "b2b2");
        idle_after(1'b0, 1'b1, "b2b2");

        // Stray start at T+3 is ignored. A single done is expected at T+8.
        frame(8'h10, 8'h20, 3, 1'b0, 1'b0, "ign");
        idle_after(1'b0, 1'b0, "ign");
        check("ign_no_extra_done", 32'(done), 32'd0);

        // Reset in mid-frame. The frame starts at T, and rst_n drops in T+4.
        pa = 8'h55;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit_a = pa[W-1-k];
            bit_b = ~pa[W-1-k];
            tick();
            start = 1'b0;
        end
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",   32'(busy),   32'd0);
        check("mid_rst_done",   32'(done),   32'd0);
        check("mid_rst_ga",     32'(ga),     32'd0);
        check("mid_rst_eq",     32'(eq),     32'd0);
        check("mid_rst_byte_a", 32'(byte_a), 32'd0);
        check("mid_rst_byte_b", 32'(byte_b), 32'd0);
        tick();
        check("mid_rst_hold_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        frame(8'hFF, 8'hFE, 0, 1'b1, 1'b0, "post_rst");
        idle_after(1'b1, 1'b0, "post_rst");

        // Random frames, sent back-to-back. The parallel reference is an
        // unsigned compare of the same operands.
        for (int n = 0; n < 500; n++) begin
            ra = W'($urandom_range(0, 127));
            rb = W'($urandom_range(0, 127));
            if (n % 7 == 0) rb = ra;
            frame(ra, rb, 0, (ra > rb), (ra == rb), "rnd");
        end
        idle_after((ra > rb), (ra == rb), "rnd_last");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_compare_byte.md
# serial_compare_byte

Bit-serial magnitude comparator: two operands arrive MSB-first on single-bit lines, one bit per clock, framed by a `start` pulse. After the last bit it reports `ga` (a > b) and `eq` (a == b), plus the deserialized operands. It is the serial-link counterpart of the parallel `compare_byte` comparator. Its deserialized outputs feed `compare_byte` directly, so the two blocks can be cross-checked against each other.

## Interface
- `WIDTH`, 8, operand width in bits (≥2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  frame start; accepted only when `busy`=0; the cycle carrying it also carries bit WIDTH-1
- `bit_a`  in  1  serial operand A, MSB first
- `bit_b`  in  1  serial operand B, MSB first
- `busy`  out  1  frame in progress, bits still expected
- `done`  out  1  one-cycle pulse: result valid
- `ga`  out  1  1 when A > B (unsigned); held until next `done`
- `eq`  out  1  1 when A == B; held until next `done`
- `byte_a`  out  WIDTH  deserialized A; updated with `done`, held otherwise
- `byte_b`  out  WIDTH  deserialized B; updated with `done`, held otherwise

## Operation
- Reset: all outputs 0, state IDLE, internal shift registers/counter/decision flags cleared.
- States:
  - IDLE: `busy`=0. `start`=1 samples bit WIDTH-1 of both lines, loads bit counter = WIDTH-1, moves to SHIFT.
  - SHIFT: `busy`=1. Samples one bit pair per cycle, decrements counter. When the final bit (bit 0) is sampled, registers results, pulses `done`, returns to IDLE.
- Decision: a `decided` flag and a `gt` flag.
  - The first bit position where `bit_a`≠`bit_b` sets `decided`=1 and `gt`=`bit_a`.
  - Later bits never change the decision.
  - If no difference is found: `ga`=0, `eq`=1.
  - Flags are cleared on each accepted `start`, including the start-cycle bit.
- `ga` and `eq` are never both 1.
- `byte_a`/`byte_b` shift left, LSB-in. The final value is exactly the transmitted operand.
- `start` while `busy`=1 is ignored. The frame continues unchanged.
- `start` in the cycle `done` is high is legal (back-to-back frames); `busy` is 0 that cycle.
- Bit lines are don't-care in IDLE without `start`.

## Timing
- `start` at cycle T. Bits WIDTH-1..0 are sampled at the rising edges ending cycles T..T+WIDTH-1.
- `busy` (registered): 1 in cycles T+1..T+WIDTH-1, 0 in cycle T+WIDTH.
- `done`: 1 only in cycle T+WIDTH. `ga`, `eq`, `byte_a`, `byte_b` update on the same edge.
- Latency: WIDTH cycles from `start` to `done`. Throughput: one frame per WIDTH cycles, with no idle gap.
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, no `done`. The partial frame is discarded; the first frame after release needs a fresh `start`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **A > B.** A=0x5A, B=0x3C (WIDTH=8), `start` at T → `done` at T+8 only, `ga`=1, `eq`=0, `byte_a`=0x5A, `byte_b`=0x3C; `busy` high T+1..T+7.
- **Equal and MSB-decided.**
  - A=B=0x7F → `ga`=0, `eq`=1.
  - Then A=0x01, B=0x80 → `ga`=0, `eq`=0 (decided at the MSB and held despite A's later 1 bit).
- **Back-to-back frames.** 0x80 vs 0x7F, then 0x00 vs 0x00, second `start` in the first frame's `done` cycle → `done` at T+8 (`ga`=1) and T+16 (`eq`=1); `busy` high T+1..T+7 and T+9..T+15, low at T+8.
- **Ignored start.** `start` pulsed at T+3 during a 0x10 vs 0x20 frame → single `done` at T+8, `ga`=0, `eq`=0, `byte_a`=0x10.
- **Reset mid-frame.** `rst_n` low at T+4 for 2 cycles → all outputs 0 immediately, no `done`. Next frame 0xFF vs 0xFE → `ga`=1.
- **Random cross-check.** 500 frames, A=$random%128, B=$random%128, `byte_a`/`byte_b` driven into `compare_byte` → at every `done`, `ga` matches `compare_byte.ga` and `eq`==(A==B).
